// File: rtl/dpd_encoder_seq.sv
// dpd_encoder_seq: sequential BCD-to-DPD IEEE 754-2008 decimal encoder, one declet per cycle.
// Ports: clk, rst_n (async, active low); in_valid/in_ready with in_sign, in_exp, in_coeff, in_special;
// out_valid/out_ready with out_data {sign, comb, exp_cont, declets} and out_flags {special, bad_digit, exp_ovf}.
module dpd_encoder_seq #(
  parameter int NDEC = 2,
  parameter int EXP_W = 8,
  localparam int NDIG = 3*NDEC+1,
  localparam int W = 4+EXP_W+10*NDEC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [4*NDIG-1:0] in_coeff,
  input  logic [1:0]        in_special,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [2:0]        out_flags
);
  localparam int CW = $clog2(NDEC);
  localparam int HW = EXP_W+4;
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12*NDEC-1:0] coeff_q, coeff_d;
  logic [10*NDEC-1:0] dec_q, dec_d;
  logic [HW-1:0] hdr_q, hdr_d;
  logic [2:0] flags_q, flags_d;
  logic zero_q, zero_d;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [2:0] out_flags_q, out_flags_d;
  logic bad, ovf, spec;
  logic [3:0] msd;
  logic [HW-1:0] fin_h, inf_h, qnan_h, snan_h, hdr_sel;
  function automatic logic [9:0] dpd(input logic [11:0] x);
    logic a, b, c, d, e, f, g, h, i, j, k, m;
    {a, b, c, d, e, f, g, h, i, j, k, m} = x;
    case ({a, e, i})
      3'b000:  dpd = {b, c, d, f, g, h, 1'b0, j, k, m};
      3'b001:  dpd = {b, c, d, f, g, h, 1'b1, 2'b00, m};
      3'b010:  dpd = {b, c, d, j, k, h, 1'b1, 2'b01, m};
      3'b100:  dpd = {j, k, d, f, g, h, 1'b1, 2'b10, m};
      3'b110:  dpd = {j, k, d, 2'b00, h, 1'b1, 2'b11, m};
      3'b101:  dpd = {f, g, d, 2'b01, h, 1'b1, 2'b11, m};
      3'b011:  dpd = {b, c, d, 2'b10, h, 1'b1, 2'b11, m};
      default: dpd = {2'b00, d, 2'b11, h, 1'b1, 2'b11, m};
    endcase
  endfunction
  always_comb begin
    bad = 1'b0;
    for (int n = 0; n < NDIG; n++) bad = bad | (in_coeff[4*n +: 4] > 4'd9);
    spec = |in_special;
    ovf = &in_exp[EXP_W-1 -: 2];
    msd = in_coeff[4*NDIG-1 -: 4];
    fin_h = {in_sign, msd[3] ? {2'b11, in_exp[EXP_W-1 -: 2], msd[0]} : {in_exp[EXP_W-1 -: 2], msd[2:0]}, in_exp[EXP_W-3:0]};
    inf_h = {in_sign, 5'b11110, {(EXP_W-2){1'b1}}};
    qnan_h = {in_sign, 5'b11111, {(EXP_W-2){1'b0}}};
    snan_h = {in_sign, 5'b11111, 1'b1, {(EXP_W-3){1'b0}}};
    // specials outrank bad digits, which outrank exponent overflow
    hdr_sel = in_special == 2'b01 ? inf_h :
              in_special == 2'b10 ? qnan_h :
              in_special == 2'b11 ? snan_h :
              bad ? qnan_h : ovf ? inf_h : fin_h;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    coeff_d = coeff_q;
    dec_d = dec_q;
    hdr_d = hdr_q;
    flags_d = flags_q;
    zero_d = zero_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_flags_d = out_flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = ENC;
        cnt_d = '0;
        coeff_d = in_coeff[12*NDEC-1:0];
        hdr_d = hdr_sel;
        flags_d = {spec, bad, ovf};
        zero_d = spec | bad | ovf;
      end
      ENC: begin
        // coefficient shifts down, declets shift in from the top: LS declet lands at bit 0
        coeff_d = coeff_q >> 12;
        dec_d = {dpd(coeff_q[11:0]), dec_q[10*NDEC-1:10]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NDEC-1)) begin
          state_d = DONE;
          out_valid_d = 1'b1;
          out_data_d = {hdr_q, zero_q ? {(10*NDEC){1'b0}} : dec_d};
          out_flags_d = flags_q;
        end
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      coeff_q <= '0;
      dec_q <= '0;
      hdr_q <= '0;
      flags_q <= '0;
      zero_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      coeff_q <= coeff_d;
      dec_q <= dec_d;
      hdr_q <= hdr_d;
      flags_q <= flags_d;
      zero_q <= zero_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_flags = out_flags_q;
endmodule

// File: doc/dpd_encoder_seq.md
Name: dpd_encoder_seq

Overview:
Parametrised sequential encoder. Accepts a sign, a biased binary exponent and a BCD coefficient, and produces an IEEE 754-2008 decimal interchange word in DPD encoding. Default is decimal32; decimal64 and decimal128 are selected by parameter. It processes one declet per cycle behind a valid/ready handshake and handles infinity/NaN inputs, invalid BCD digits and exponent overflow. It sits between the BCD arithmetic datapath and the result write-back/memory interface.

Parameters:
NDEC, 2, number of trailing 10-bit declets (2 = decimal32, 5 = decimal64, 11 = decimal128).
EXP_W, 8, biased exponent width (8 / 10 / 14 for the three formats).
Derived constants (not overridable):
- NDIG = 3*NDEC+1 (coefficient digits).
- W = 4+EXP_W+10*NDEC (output width: 32 / 64 / 128).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input word valid.
in_ready  out  1  encoder can accept an input.
in_sign  in  1  sign bit.
in_exp  in  EXP_W  biased exponent.
in_coeff  in  4*NDIG  BCD coefficient; MSD in the top nibble.
in_special  in  2  00 finite, 01 infinity, 10 qNaN, 11 sNaN.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_data  out  W  encoded word {sign, comb[4:0], exp_cont[EXP_W-3:0], declet[NDEC-1]..declet[0]}.
out_flags  out  3  {special, bad_digit, exp_ovf}.

Behaviour:
Reset (asynchronous, rst_n low):
- State IDLE; out_valid=0; out_data=0; out_flags=0; declet counter=0.
- in_ready=1 once rst_n is high.
- Reset asserted mid-encode aborts the operation; no partial result is ever emitted.

FSM IDLE -> ENC -> DONE:
- IDLE: in_ready=1. When in_valid=1, the encoder captures all inputs, computes bad_digit (any nibble >9) and exp_ovf (in_exp[EXP_W-1:EXP_W-2]==2'b11), and goes to ENC.
- ENC: in_ready=0. Encodes declet k (digits 3k+2, 3k+1, 3k) in cycle k, LS declet first, k = 0..NDEC-1. After the last declet it goes to DONE.
- DONE: out_valid=1 and out_data/out_flags are held stable until out_ready=1, then it returns to IDLE. Back-to-back inputs are not overlapped.
- Latency: accept at cycle T gives out_valid at cycle T+NDEC+1 (3 cycles for decimal32). Throughput is one word per NDEC+2 cycles when out_ready is held high.

Declet encoding, digit bits D2=abcd, D1=efgh, D0=ijkm, L = digit >7 (msb set); output pqr stu v wxy:
- sss: bcd fgh 0 jkm
- ssL: bcd fgh 1 00m
- sLs: bcd jkh 1 01m
- Lss: jkd fgh 1 10m
- LLs: jkd 00h 1 11m
- LsL: fgd 01h 1 11m
- sLL: bcd 10h 1 11m
- LLL: 00d 11h 1 11m (unused bits are 0, never X).

Combination field, MSD = in_coeff top nibble, Et = in_exp top 2 bits:
- MSD <= 7: comb = {Et, MSD[2:0]}.
- MSD > 7: comb = {2'b11, Et, MSD[0]}.
- exp_cont = in_exp[EXP_W-3:0].

Result precedence (highest first):
- in_special != 00 -> special=1. Infinity: comb=11110, exp_cont all ones, declets 0. qNaN: comb=11111, exp_cont all 0. sNaN: comb=11111, exp_cont MSB=1, rest 0. Declets 0 for both NaNs. The sign bit passes through in all cases.
- bad_digit -> qNaN encoding, bad_digit=1.
- exp_ovf -> infinity encoding (as above) with in_sign, exp_ovf=1.
- Otherwise the finite encoding, flags 0.
- Lower-priority flags are still reported alongside a higher-priority result; only the result word follows the precedence.

Handshake:
- in_valid is ignored while in_ready=0.
- out_ready may be held high in advance; the result is then consumed in its first valid cycle.

Test Plan:
- Decimal32, sign 0, exp 8'h65, coeff BCD 28'h1234567, special 00 -> out_data 32'h2654D2E7, flags 0, out_valid exactly 3 cycles after accept.
- Decimal32, exp 8'h65, coeff 28'h9999999 (MSD>7, LLL declets) -> 32'h6E53FCFF.
- Coeff 28'h12A4567 -> 32'h7C000000, flags 3'b010. Then sign 1, exp 8'hC0, coeff 0 -> 32'hFBF00000, flags 3'b001.
- special 11 (sNaN), sign 0 -> 32'h7E000000, flags 3'b100. special 01, sign 1 -> 32'hFBF00000.
- NDEC=5, EXP_W=10: exp 10'h18E, coeff 1 -> 64'h2238000000000001, out_valid 6 cycles after accept.
- Hold out_ready low 10 cycles: out_data stable and in_ready=0 throughout. Assert rst_n low in ENC: out_valid stays 0 and in_ready=1 after release.
